// File: rtl/npu_fixed_pkg.sv
// npu_fixed_pkg: shared Q8.8 fixed-point type and saturation bounds
package npu_fixed_pkg;
    typedef logic signed [15:0] q88_t;
    localparam q88_t Q88_MAX = 16'sh7FFF;
    localparam q88_t Q88_MIN = 16'sh8000;
endpackage

// File: rtl/fixed_add_16.sv
// fixed_add_16: combinational Q8.8 saturating adder
module fixed_add_16
    import npu_fixed_pkg::*;
(
    input  q88_t a,
    input  q88_t b,
    output q88_t sum
);
    logic signed [16:0] s;
    assign s = 17'(a) + 17'(b);
    assign sum = (s > 17'(Q88_MAX)) ? Q88_MAX : (s < 17'(Q88_MIN)) ? Q88_MIN : s[15:0];
endmodule

// File: rtl/q88_add_arbiter.sv
// q88_add_arbiter: round-robin shared Q8.8 saturating adder with one registered result slot
module q88_add_arbiter
    import npu_fixed_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ),
    parameter  int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*16-1:0]   req_a,
    input  logic [NUM_REQ*16-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_sum,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_sat,
    output logic [CNT_W-1:0]        sat_count,
    input  logic                    sat_clr
);
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gid;
    logic [NUM_REQ-1:0] rot;
    logic               found;
    logic               can_issue;
    logic               fire;
    logic               sat;
    int                 t;
    q88_t               a_sel;
    q88_t               b_sel;
    q88_t               sum;
    logic signed [16:0] wide;
    assign can_issue = !rsp_valid || rsp_ready;
    assign rot = NUM_REQ'({req_valid, req_valid} >> ptr);
    // descending scan so the lowest rotated offset from ptr wins
    always_comb begin
        found = 1'b0;
        t = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                t = int'(ptr) + k;
            end
        end
        gid = ID_W'(t >= NUM_REQ ? t - NUM_REQ : t);
    end
    assign req_ready = (found && can_issue) ? NUM_REQ'(1) << gid : '0;
    assign fire = |req_ready;
    assign a_sel = req_a[16*gid +: 16];
    assign b_sel = req_b[16*gid +: 16];
    fixed_add_16 u_add (
        .a   (a_sel),
        .b   (b_sel),
        .sum (sum)
    );
    assign wide = 17'(a_sel) + 17'(b_sel);
    assign sat = (wide > 17'(Q88_MAX)) || (wide < 17'(Q88_MIN));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            rsp_sat   <= 1'b0;
            sat_count <= '0;
            ptr       <= '0;
        end else begin
            if (fire) begin
                rsp_valid <= 1'b1;
                rsp_sum   <= sum;
                rsp_id    <= gid;
                rsp_sat   <= sat;
                ptr       <= (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (sat_clr)
                sat_count <= '0;
            else if (fire && sat && !(&sat_count))
                sat_count <= sat_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_q88_add_arbiter.sv
// tb_q88_add_arbiter: directed self-checking bench for q88_add_arbiter
module tb_q88_add_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_sum;
    logic [1:0]  rsp_id;
    logic        rsp_sat;
    logic [3:0]  sat_count;
    logic        sat_clr;
    int checks = 0;
    int errors = 0;

    q88_add_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_sat   (rsp_sat),
        .sat_count (sat_count),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        sat_clr = 1'b0;
        step();
        checks++;
        if ({rsp_valid, rsp_sum, rsp_id, rsp_sat, sat_count, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset: got valid=%b sum=%h id=%0d sat=%b cnt=%0d ready=%b, want all zero",
                     rsp_valid, rsp_sum, rsp_id, rsp_sat, sat_count, req_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        set_req(2, 16'h0180, 16'h0240);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got %b, want 0100", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 16'h03C0 || rsp_id !== 2'd2 || rsp_sat !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: got valid=%b sum=%h id=%0d sat=%b, want 1 03c0 2 0",
                     rsp_valid, rsp_sum, rsp_id, rsp_sat);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_sum [4] = '{16'h0010, 16'h0110, 16'h0210, 16'h0310};
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 16'(i * 256), 16'h0010);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b, want %b", k, req_ready, 4'(1 << (k % 4)));
            end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_sum !== exp_sum[k % 4]) begin
                errors++;
                $display("FAIL rr_rsp[%0d]: got valid=%b id=%0d sum=%h, want 1 %0d %h",
                         k, rsp_valid, rsp_id, rsp_sum, k % 4, exp_sum[k % 4]);
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_saturation();
        set_req(0, 16'h7F00, 16'h0200);
        req_valid = 4'b0001;
        step();
        checks++;
        if (rsp_sum !== 16'h7FFF || rsp_sat !== 1'b1 || sat_count !== 4'd1 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL sat_pos: got sum=%h sat=%b cnt=%0d id=%0d, want 7fff 1 1 0",
                     rsp_sum, rsp_sat, sat_count, rsp_id);
        end
        set_req(0, 16'h8100, 16'hFE00);
        step();
        checks++;
        if (rsp_sum !== 16'h8000 || rsp_sat !== 1'b1 || sat_count !== 4'd2) begin
            errors++;
            $display("FAIL sat_neg: got sum=%h sat=%b cnt=%0d, want 8000 1 2",
                     rsp_sum, rsp_sat, sat_count);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        // slot still holds 8000 from requester 0; ptr now points at requester 1
        rsp_ready = 1'b0;
        set_req(0, 16'h0100, 16'h0100);
        set_req(1, 16'h0300, 16'h0001);
        req_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_sum !== 16'h8000 ||
                rsp_id !== 2'd0 || rsp_sat !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ready=%b valid=%b sum=%h id=%0d sat=%b, want 0000 1 8000 0 1",
                         k, req_ready, rsp_valid, rsp_sum, rsp_id, rsp_sat);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_grant: got %b, want 0010", req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0301 || rsp_id !== 2'd1 || rsp_sat !== 1'b0 || sat_count !== 4'd2) begin
            errors++;
            $display("FAIL bp_release_rsp: got valid=%b sum=%h id=%0d sat=%b cnt=%0d, want 1 0301 1 0 2",
                     rsp_valid, rsp_sum, rsp_id, rsp_sat, sat_count);
        end
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_wrap_grant: got %b, want 0001", req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0200 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL bp_wrap_rsp: got valid=%b sum=%h id=%0d, want 1 0200 0",
                     rsp_valid, rsp_sum, rsp_id);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_sat_clr();
        set_req(0, 16'h7F00, 16'h0200);
        req_valid = 4'b0001;
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        checks++;
        if (sat_count !== 4'd0 || rsp_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_clr_priority: got cnt=%0d sat=%b, want 0 1", sat_count, rsp_sat);
        end
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 15 || k == 17) begin
                checks++;
                if (sat_count !== 4'hF) begin
                    errors++;
                    $display("FAIL sat_cnt_ceiling[%0d]: got %0d, want 15", k, sat_count);
                end
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_async_reset();
        set_req(2, 16'h0001, 16'h0002);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_sum, rsp_id, rsp_sat, sat_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b sum=%h id=%0d sat=%b cnt=%0d, want all zero",
                     rsp_valid, rsp_sum, rsp_id, rsp_sat, sat_count);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 16'h0020, 16'(i));
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_grant: got %b, want 0001", req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 16'h0020) begin
            errors++;
            $display("FAIL post_reset_rsp: got valid=%b id=%0d sum=%h, want 1 0 0020",
                     rsp_valid, rsp_id, rsp_sum);
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_saturation();
        test_backpressure();
        test_sat_clr();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/q88_add_arbiter.md
Name: q88_add_arbiter

Overview:
- Shares one 16-bit Q8.8 saturating adder among NUM_REQ requesters, such as PE lanes or partial-sum reducers in the NPU datapath.
- Arbitration is round-robin, one grant per cycle.
- Request and response sides use valid/ready handshakes; the response is a single registered output slot tagged with requester ID and a saturation flag.
- A saturation-event counter is kept for debug and quantisation tuning.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the requester ID; derived, not overridden.
- CNT_W, 16, width of the saturation-event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*16  packed Q8.8 operand A; requester i occupies [16*i+15:16*i].
- req_b  in  NUM_REQ*16  packed Q8.8 operand B; same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; requester i's request is accepted when req_valid[i] && req_ready[i].
- rsp_valid  out  1  result slot full.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  16  saturated Q8.8 sum.
- rsp_id  out  ID_W  index of the requester that produced rsp_sum.
- rsp_sat  out  1  high when rsp_sum was clamped.
- sat_count  out  CNT_W  number of saturated results accepted into the slot.
- sat_clr  in  1  synchronous clear of sat_count.

Behaviour:
- Reset values:
  - rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_sat=0.
  - sat_count=0.
  - Round-robin pointer ptr=0.
  - req_ready is combinational and evaluates to 0 while rsp_valid is 0 and no req_valid is set.
- Slot availability: can_issue = !rsp_valid || rsp_ready.
- Grant is combinational:
  - When can_issue, req_ready has exactly one bit set: the first i with req_valid[i], scanning ptr, ptr+1, … modulo NUM_REQ.
  - Otherwise req_ready is all zero.
  - req_ready never asserts for a requester whose req_valid is low.
- On a handshake for requester g:
  - Next cycle: rsp_valid=1, rsp_sum=sat(A_g+B_g), rsp_id=g, rsp_sat=flag.
  - ptr <= (g+1) mod NUM_REQ.
  - Latency is 1 cycle from handshake to rsp_valid.
  - Full throughput: one result per cycle while rsp_ready stays high.
- With no handshake:
  - If rsp_valid && rsp_ready, rsp_valid <= 0.
  - Otherwise the slot holds.
  - ptr is unchanged.
- Simultaneous drain and issue (rsp_valid && rsp_ready plus a new handshake) loads the new result with no bubble.
- Arithmetic:
  - Form the 17-bit signed sum A+B.
  - If the sum > 32767, output 16'h7FFF with sat=1.
  - If the sum < -32768, output 16'h8000 with sat=1.
  - Otherwise output sum[15:0] with sat=0.
- Hold rule: while rsp_valid && !rsp_ready, rsp_sum, rsp_id and rsp_sat are stable and no request is accepted.
- sat_count:
  - Increments by 1 when a saturated result is loaded into the slot.
  - Saturates at all-ones and does not wrap.
  - sat_clr has priority: the counter becomes 0 even if an increment occurs the same cycle.
- Requesters must hold req_a, req_b and req_valid until their handshake; this is not checked by the block.
- Reset asserted mid-operation: every register returns immediately to its reset value, and any pending result is dropped.

Decomposition:
- Shared package npu_fixed_pkg:
  - Q88_MAX=16'sh7FFF, Q88_MIN=16'sh8000.
  - typedef q88_t (logic signed [15:0]).
- Sub-module: instantiate the existing combinational fixed_add_16 for the sum.
  - rsp_sat is derived in this block from the 17-bit sum using the same bounds.
- Keep in this block: the round-robin arbiter and the output slot.
  - A separate rr_arbiter sub-module is optional.

Test Plan:
1. Reset, then only req_valid[2] with A=0x0180 (1.5), B=0x0240 (2.25), rsp_ready=1 → req_ready=0100; next cycle rsp_sum=0x03C0, rsp_id=2, rsp_sat=0.
2. All four valid continuously, rsp_ready=1, from reset → grants 0,1,2,3,0,1 on consecutive cycles; one response per cycle, each rsp_id matching its grant.
3. A=0x7F00, B=0x0200 → rsp_sum=0x7FFF, rsp_sat=1, sat_count=1. Then A=0x8100, B=0xFE00 → rsp_sum=0x8000, sat_count=2.
4. Backpressure: rsp_ready=0 for 3 cycles with requesters 0 and 1 valid → req_ready=0 throughout and rsp_* stable. When rsp_ready rises, the next grant goes to the requester after the last granted one, and the new result loads the following cycle with no bubble.
5. sat_clr asserted in the same cycle as a saturating load → sat_count=0 next cycle. Separately, force the counter to all-ones with further saturations → it stays at all-ones.
6. Assert rst_n=0 while rsp_valid=1 mid-stream → outputs and ptr reset without waiting for a clock edge. After release, requester 0 has first priority.
